dm_responder: RTL
=================

// Module: dm_responder
// PURPOSE
// - Data-memory responder on the core's M-stage data port: serves m_data_addr/m_data_byteen/m_data_wdata, returns m_data_rdata.
// - Combinational word read; byte-lane write on the clock edge.
// - Each committed store is logged into a trace FIFO drained by a valid/ready port, for the store-ordering checker.
// PARAMETERS
// - DEPTH_WORDS   3072  RAM size in 32-bit words (12 KB); byte addresses 0 .. DEPTH_WORDS*4-1.
// - FIFO_DEPTH    8     trace FIFO entries; power of two, >= 2.
// PORTS
// - clk            in   1   single clock; all state updates on the rising edge.
// - reset          in   1   asynchronous, active-low reset (0 = reset asserted).
// - m_data_addr    in   32  byte address from the core; bits [1:0] ignored for indexing.
// - m_data_wdata   in   32  store data, already lane-aligned by the core's byte-enable unit.
// - m_data_byteen  in   4   byte write enables, bit i -> bits [8i+7:8i]; 4'b0000 = no store.
// - m_inst_addr    in   32  PC of the M-stage instruction, recorded in the trace.
// - m_data_rdata   out  32  word at m_data_addr[.. :2].
// - trace_valid    out  1   trace FIFO non-empty.
// - trace_ready    in   1   consumer accepts the head entry this cycle.
// - trace_pc       out  32  head entry: store PC.
// - trace_addr     out  32  head entry: word-aligned address ({addr[31:2],2'b00}).
// - trace_data     out  32  head entry: full word after the merge.
// - trace_byteen   out  4   head entry: byte enables of the store.
// - trace_count    out  $clog2(FIFO_DEPTH)+1  occupancy.
// - ovf            out  1   sticky: a store was dropped from the trace because the FIFO was full.
// - err            out  1   sticky: an access with byteen!=0 targeted an out-of-range address.
// BEHAVIOUR
// - Reset (reset==0, asynchronous): all RAM words = 0; FIFO empty (pointers and count = 0).
//   ovf = err = 0; trace_valid = 0; trace_* data outputs = 0; m_data_rdata = 0.
// - Index = m_data_addr[31:2]. In range iff index < DEPTH_WORDS.
// - Read: m_data_rdata = RAM[index] combinationally; out of range -> 32'h0. Zero cycle latency.
// - Write: on posedge with byteen!=0 and in range, each enabled lane of RAM[index] <= the matching lane of m_data_wdata.
//   Disabled lanes are kept.
// - Same-cycle read of the word being written returns the OLD value; the new value is visible from the next cycle.
// - Out-of-range store: RAM unchanged, no trace push, err <= 1.
//   An out-of-range access with byteen==0 does not set err.
// - Trace push: any in-range store (byteen!=0). Entry =
//   {m_inst_addr, {m_data_addr[31:2],2'b00}, merged word, m_data_byteen}.
//   The merged word is the old word with the enabled lanes replaced.
// - Trace pop: trace_valid && trace_ready on a posedge. The head advances; trace_* show the next entry (FIFO order) combinationally.
// - Simultaneous push and pop: count unchanged; allowed even when full, since the pop frees the slot and the push is accepted.
// - Push while full without pop: RAM write still happens, the entry is dropped, ovf <= 1.
// - Pop while empty: ignored, count stays 0.
// - Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
// - ovf and err clear only on reset.
// - Reset mid-stream: in-flight FIFO contents are discarded; no partial RAM write on the edge where reset is asserted.
// - Must not stall the core: there is no busy/wait output, and RAM writes never depend on trace_ready.
// TESTING
// - Store word: addr 0x10, byteen 4'b1111, wdata 0xDEADBEEF, pc 0x3004 -> next cycle rdata@0x10 = 0xDEADBEEF;
//   trace = {0x3004, 0x10, 0xDEADBEEF, 4'hF}.
// - Byte/half merge: word 0x10 = 0xDEADBEEF, then byteen 4'b0100 wdata 0x00AA0000 -> 0xDEAABEEF;
//   then byteen 4'b0011 wdata 0x00001234 -> 0xDEAA1234.
// - Read-during-write: store 0x11111111 to 0x20 (old value 0), sample rdata in the same cycle -> 0;
//   sample in the next cycle -> 0x11111111.
// - FIFO full, FIFO_DEPTH=8, trace_ready=0: 9 stores -> count=8, ovf=1, the 9th word is in RAM but absent from the trace.
//   Then push+pop in the same cycle -> count stays 8, ovf stays 1.
// - Range: store to 0x3000 (index 3072) -> err=1, no trace entry, rdata@0x3000 = 0;
//   read with byteen=0 at 0x4000 -> err unchanged.
// - Reset mid-operation: 3 entries queued, pull reset low between edges -> trace_valid=0, count=0, ovf=err=0 immediately;
//   rdata@0x10 = 0.

Source files
------------

// File: rtl/dm_responder.sv
// Data-memory responder: combinational word read, byte-lane store on the rising edge, store trace FIFO.
// Latency: reads 0 cycles, stores visible next cycle. Backpressure: none toward the core; full trace drops and flags ovf.
// Trace consumer uses valid/ready; pop and push in the same cycle are both accepted even when full.
module dm_responder #(
    parameter int DEPTH_WORDS = 3072,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   m_data_addr,
    input  logic [31:0]                   m_data_wdata,
    input  logic [3:0]                    m_data_byteen,
    input  logic [31:0]                   m_inst_addr,
    output logic [31:0]                   m_data_rdata,
    output logic                          trace_valid,
    input  logic                          trace_ready,
    output logic [31:0]                   trace_pc,
    output logic [31:0]                   trace_addr,
    output logic [31:0]                   trace_data,
    output logic [3:0]                    trace_byteen,
    output logic [$clog2(FIFO_DEPTH):0]   trace_count,
    output logic                          ovf,
    output logic                          err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  byteen;
    } trace_t;

    logic [31:0]   ram [DEPTH_WORDS];
    trace_t        fifo [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [31:0]   word_idx;
    logic          in_range;
    logic [AW-1:0] ram_idx;
    logic [31:0]   old_word;
    logic [31:0]   merged;
    logic          store_ok;
    logic          is_full;
    logic          pop;
    logic          push;
    logic          drop;
    trace_t        head;
    trace_t        new_entry;
    logic [1:0]    unused_addr_lsb;

    assign unused_addr_lsb = m_data_addr[1:0];

    always_comb begin
        word_idx = {2'b00, m_data_addr[31:2]};
        in_range = word_idx < 32'(DEPTH_WORDS);
        ram_idx  = m_data_addr[AW+1:2];
        old_word = in_range ? ram[ram_idx] : 32'h0;
        merged   = old_word;
        for (int b = 0; b < 4; b++) begin
            if (m_data_byteen[b]) begin
                merged[8*b +: 8] = m_data_wdata[8*b +: 8];
            end
        end
    end

    assign m_data_rdata = old_word;

    assign store_ok = (m_data_byteen != 4'b0000) && in_range;
    assign is_full  = (count == CW'(FIFO_DEPTH));
    assign pop      = trace_valid && trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push     = store_ok && (!is_full || pop);
    assign drop     = store_ok && is_full && !pop;

    assign new_entry = '{pc: m_inst_addr, addr: {m_data_addr[31:2], 2'b00},
                         data: merged, byteen: m_data_byteen};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                ram[i] <= 32'h0;
            end
        end else if (store_ok) begin
            ram[ram_idx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end
            if ((m_data_byteen != 4'b0000) && !in_range) begin
                err <= 1'b1;
            end
        end
    end

    assign trace_valid = (count != '0);
    assign trace_count = count;
    // Head fields read as zero while empty so stale entries never leak after reset or drain.
    assign head         = fifo[rd_ptr];
    assign trace_pc     = trace_valid ? head.pc     : 32'h0;
    assign trace_addr   = trace_valid ? head.addr   : 32'h0;
    assign trace_data   = trace_valid ? head.data   : 32'h0;
    assign trace_byteen = trace_valid ? head.byteen : 4'h0;

endmodule
